dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the pipelined ARM core: services the Memory-stage load/store requests issued by the datapath (address `ALUResultM`, store data `WriteDataM`) and returns `ReadDataM`. Models a fixed-latency word RAM with byte-lane support. Raises `StallM` to the hazard unit while an access is in flight, so the pipeline freezes until data is ready.

## Interface
Parameters:
- `DEPTH_WORDS`, 64: number of 32-bit words; power of two, ≥ 4.
- `LATENCY`, 2: cycles from acceptance to response; legal range 1–15.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high.
- `MemReqM`  in  1  M-stage instruction is a condition-passed load or store.
- `MemWriteM`  in  1  1 = store, 0 = load; sampled with `MemReqM`.
- `ByteM`  in  1  byte access (LDRB/STRB); 0 = word access.
- `ALUResultM`  in  32  byte address.
- `WriteDataM`  in  32  store data; byte stores use bits [7:0].
- `ReadDataM`  out  32  load result; valid in the RESP cycle.
- `StallM`  out  1  access in progress; hazard unit holds F/D/E/M and bubbles W.
- `ErrM`  out  1  one-cycle fault pulse in RESP (misaligned or out-of-range access).

## Operation
- FSM states are IDLE, WAIT and RESP.
- **IDLE**
  - `MemReqM`=1: latch address, data, `MemWriteM` and `ByteM`; load the counter with `LATENCY`-1.
  - Next state is WAIT, or RESP when `LATENCY`=1.
  - `MemReqM`=0: stay in IDLE.
- **WAIT**: decrement the counter; go to RESP when it reaches 0. Inputs are ignored, because the latched copy is authoritative.
- **RESP**: go to IDLE unconditionally. The same held instruction is still presenting `MemReqM`, and it must not be re-accepted.
- `StallM` = (IDLE & `MemReqM`) | WAIT. It is combinational, so the request is frozen in M in the same cycle it appears.
- **Addressing**
  - Word index = addr[log2(`DEPTH_WORDS`)+1:2].
  - Little-endian lanes: lane k = bits [8k+7:8k], where k = addr[1:0].
- **Loads**
  - Word load: `ReadDataM` = the word.
  - Byte load: `ReadDataM` = zero-extended lane byte.
  - The array is read on the edge entering RESP.
- **Stores**
  - Committed on the clock edge that ends RESP.
  - Word store writes all four lanes; byte store writes only lane addr[1:0] with data[7:0].
  - A store drives `ReadDataM` = 0 in RESP.
- **Faults**
  - Conditions: word access with addr[1:0]≠0, or addr ≥ 4·`DEPTH_WORDS`.
  - Response: `ErrM`=1 in RESP, `ReadDataM`=0, store suppressed, memory unchanged.
- Outside RESP, `ReadDataM` holds its last value.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: state IDLE, counter 0, `ReadDataM` 0, `ErrM` 0. `StallM` is forced to 0 while `reset` is high.
- Request present at cycle T:
  - `StallM` is high for cycles T … T+`LATENCY`-1.
  - RESP occurs at T+`LATENCY` with `StallM`=0; the pipeline advances at the end of that cycle.
  - Total occupancy is `LATENCY`+1 cycles per access.
- Back-to-back accesses: the earliest next acceptance is T+`LATENCY`+1. A load there observes a store completed at T+`LATENCY` (read-after-write is coherent, no bypass needed).
- Reset asserted mid-access (WAIT or RESP): the access is aborted, no store is committed, and the FSM is in IDLE immediately.
- `MemReqM` deasserting during WAIT has no effect; the access completes.

## Structure
- Package `mem_pkg`:
  - `mem_state_t` enum {IDLE, WAIT, RESP};
  - `WORD_BYTES`=4;
  - function `idx_width(depth)` = $clog2(depth).
- Sub-module `dmem_array`: `DEPTH_WORDS`×32 storage with a synchronous registered read, a synchronous write, and a 4-bit lane write-enable.
- `dmem_responder` contains the FSM, counter, fault decode and lane select/merge.

## Test plan
- Store word 0xDEADBEEF to 0x10, then load word from 0x10 (`LATENCY`=2) → `StallM` high 2 cycles per access; RESP of the load gives `ReadDataM`=0xDEADBEEF; `ErrM`=0.
- Store byte 0xA5 to 0x13 over word 0x11223344 at 0x10; load word 0x10 → 0xA5223344; load byte 0x13 → 0x000000A5.
- Load word from 0x12 (misaligned) and store to 0x100 with `DEPTH_WORDS`=64 → `ErrM` pulses one cycle in each RESP; load `ReadDataM`=0; memory at 0x100 mod range unchanged.
- `LATENCY`=1: back-to-back loads in consecutive instructions → `StallM` high exactly 1 cycle each; accepts at T and T+2; held `MemReqM` during RESP is not re-accepted.
- Assert `reset` during WAIT of a store 0x55 to 0x20 → FSM IDLE, `StallM`=0, `ReadDataM`=0; subsequent load of 0x20 returns the prior contents.
- Drop `MemReqM` in WAIT → access still completes at T+`LATENCY` with correct data.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder.
package mem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned CNT_W      = 4;

  // Number of word-index bits for a power-of-two depth.
  function automatic int unsigned idx_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word RAM with registered read and per-byte-lane synchronous write.
// Ports:
//   clk      - clock
//   rd_en    - capture mem[rd_idx] into rd_data on this edge
//   rd_idx   - read word index
//   rd_data  - registered read data (holds when rd_en is low)
//   wr_be    - byte-lane write enables, lane k = bits [8k+7:8k]
//   wr_idx   - write word index
//   wr_data  - write data, lanes selected by wr_be
module dmem_array
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned IW          = idx_width(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [IW-1:0]         rd_idx,
  output logic [DATA_W-1:0]     rd_data,
  input  logic [WORD_BYTES-1:0] wr_be,
  input  logic [IW-1:0]         wr_idx,
  input  logic [DATA_W-1:0]     wr_data
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  // Read port holds its last value between reads.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_idx];
  end

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    rd_data_q <= rd_data_d;
    for (int k = 0; k < int'(WORD_BYTES); k++) begin
      if (wr_be[k]) mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for the M stage of the pipeline.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   MemReqM     - condition-passed load/store present in M
//   MemWriteM   - 1 = store, 0 = load
//   ByteM       - byte access (LDRB/STRB), 0 = word
//   ALUResultM  - byte address
//   WriteDataM  - store data (byte stores use [7:0])
//   ReadDataM   - load result, valid in RESP, held otherwise
//   StallM      - combinational stall to the hazard unit
//   ErrM        - one-cycle fault pulse in RESP
module dmem_responder
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic              ByteM,
  input  logic [DATA_W-1:0] ALUResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallM,
  output logic              ErrM
);

  localparam int unsigned IW = idx_width(DEPTH_WORDS);
  // Byte-address bits that fall inside the array.
  localparam int unsigned AW = IW + 2;

  mem_state_t        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_q, wr_d;
  logic              byte_q, byte_d;
  logic              fault_q, fault_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;

  logic                  in_fault_c;
  logic                  rd_en_c;
  logic [IW-1:0]         rd_idx_c;
  logic [DATA_W-1:0]     arr_rdata;
  logic [WORD_BYTES-1:0] wr_be_c;
  logic [DATA_W-1:0]     wr_data_c;
  logic [7:0]            lane_c;
  logic [DATA_W-1:0]     resp_data_c;

  // Out of range, or a word access not on a word boundary.
  assign in_fault_c = (ALUResultM[DATA_W-1:AW] != '0) |
                      (~ByteM & (ALUResultM[1:0] != 2'b00));

  // Sequencer next state and request latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    byte_d  = byte_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (MemReqM) begin
          addr_d  = ALUResultM[AW-1:0];
          wdata_d = WriteDataM;
          wr_d    = MemWriteM;
          byte_d  = ByteM;
          fault_d = in_fault_c;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_d == '0) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Array read happens on the edge entering RESP; with LATENCY=1 that is
  // the accepting edge, so the index comes straight from the input then.
  assign rd_en_c  = (state_d == RESP);
  assign rd_idx_c = (state_q == IDLE) ? ALUResultM[AW-1:2] : addr_q[AW-1:2];
  assign err_d    = (state_d == RESP) & fault_d;

  // Store commits on the edge leaving RESP unless it faulted.
  always_comb begin
    wr_be_c   = '0;
    wr_data_c = byte_q ? {WORD_BYTES{wdata_q[7:0]}} : wdata_q;
    if ((state_q == RESP) & wr_q & ~fault_q) begin
      wr_be_c = byte_q ? (WORD_BYTES'(1) << addr_q[1:0]) : '1;
    end
  end

  // Lane select and response data for RESP.
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_c = arr_rdata[7:0];
      2'd1:    lane_c = arr_rdata[15:8];
      2'd2:    lane_c = arr_rdata[23:16];
      default: lane_c = arr_rdata[31:24];
    endcase
    if (fault_q | wr_q) resp_data_c = '0;
    else if (byte_q)    resp_data_c = {24'd0, lane_c};
    else                resp_data_c = arr_rdata;
  end

  assign read_data_d = (state_q == RESP) ? resp_data_c : read_data_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wr_q        <= 1'b0;
      byte_q      <= 1'b0;
      fault_q     <= 1'b0;
      err_q       <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wr_q        <= wr_d;
      byte_q      <= byte_d;
      fault_q     <= fault_d;
      err_q       <= err_d;
      read_data_q <= read_data_d;
    end
  end

  dmem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IW         (IW)
  ) u_array (
    .clk    (clk),
    .rd_en  (rd_en_c),
    .rd_idx (rd_idx_c),
    .rd_data(arr_rdata),
    .wr_be  (wr_be_c),
    .wr_idx (addr_q[AW-1:2]),
    .wr_data(wr_data_c)
  );

  // Combinational so the requesting instruction freezes in its first cycle.
  assign StallM    = ~reset & (((state_q == IDLE) & MemReqM) | (state_q == WAIT));
  assign ReadDataM = (state_q == RESP) ? resp_data_c : read_data_q;
  assign ErrM      = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_a = 1'b0, req_b = 1'b0;
  logic        mem_write = 1'b0, byte_m = 1'b0;
  logic [31:0] alu_result = '0, write_data = '0;
  logic [31:0] rdata_a, rdata_b;
  logic        stall_a, stall_b, err_a, err_b;
  int          cyc = 0;
  int          vecs = 0;
  int          errs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) dut_a (
    .clk(clk), .reset(reset), .MemReqM(req_a), .MemWriteM(mem_write), .ByteM(byte_m),
    .ALUResultM(alu_result), .WriteDataM(write_data),
    .ReadDataM(rdata_a), .StallM(stall_a), .ErrM(err_a));

  dmem_responder #(.DEPTH_WORDS(64), .LATENCY(1)) dut_b (
    .clk(clk), .reset(reset), .MemReqM(req_b), .MemWriteM(mem_write), .ByteM(byte_m),
    .ALUResultM(alu_result), .WriteDataM(write_data),
    .ReadDataM(rdata_b), .StallM(stall_b), .ErrM(err_b));

  // Runs one access on instance sel (0: LATENCY=2, 1: LATENCY=1); called at posedge+1.
  task automatic access(input bit sel, input bit wr, input bit byt,
                        input logic [31:0] addr, input logic [31:0] data, input bit drop,
                        output int acc_cyc, output int stalls, output int resp_at,
                        output logic [31:0] rd, output logic err,
                        output logic [31:0] rd_after, output logic err_after);
    mem_write = wr; byte_m = byt; alu_result = addr; write_data = data;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    acc_cyc = cyc; stalls = 0; resp_at = -1; rd = 'x; err = 1'bx;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (sel ? stall_b : stall_a) stalls++;
      else begin
        resp_at = c;
        rd  = sel ? rdata_b : rdata_a;
        err = sel ? err_b : err_a;
      end
      @(posedge clk); #1;
      if (drop && c == 0) begin req_a = 1'b0; req_b = 1'b0; end
      if (resp_at >= 0) break;
    end
    req_a = 1'b0; req_b = 1'b0;
    rd_after  = sel ? rdata_b : rdata_a;
    err_after = sel ? err_b : err_a;
  endtask

  int          t_acc, t_st, t_resp, t_acc2;
  logic [31:0] t_rd, t_rda;
  logic        t_err, t_erra;

  task automatic test_reset();
    req_a = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vecs++; if (stall_a !== 1'b0) begin errs++; $display("FAIL reset_stall got %b want 0", stall_a); end
    vecs++; if (rdata_a !== 32'h0) begin errs++; $display("FAIL reset_rdata got %h want 00000000", rdata_a); end
    vecs++; if (err_a !== 1'b0) begin errs++; $display("FAIL reset_err got %b want 0", err_a); end
    req_a = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_word();
    access(0, 1, 0, 32'h10, 32'hDEADBEEF, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_st !== 2) begin errs++; $display("FAIL sw_stall got %0d want 2", t_st); end
    vecs++; if (t_resp !== 2) begin errs++; $display("FAIL sw_resp got %0d want 2", t_resp); end
    vecs++; if (t_rd !== 32'h0) begin errs++; $display("FAIL sw_rdata got %h want 00000000", t_rd); end
    access(0, 0, 0, 32'h10, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_st !== 2) begin errs++; $display("FAIL lw_stall got %0d want 2", t_st); end
    vecs++; if (t_rd !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_rdata got %h want deadbeef", t_rd); end
    vecs++; if (t_err !== 1'b0) begin errs++; $display("FAIL lw_err got %b want 0", t_err); end
    vecs++; if (t_rda !== 32'hDEADBEEF) begin errs++; $display("FAIL lw_hold got %h want deadbeef", t_rda); end
  endtask

  task automatic test_byte();
    access(0, 1, 0, 32'h10, 32'h11223344, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    access(0, 1, 1, 32'h13, 32'h123456A5, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_err !== 1'b0) begin errs++; $display("FAIL sb_err got %b want 0", t_err); end
    access(0, 0, 0, 32'h10, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_rd !== 32'hA5223344) begin errs++; $display("FAIL sb_word got %h want a5223344", t_rd); end
    access(0, 0, 1, 32'h13, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_rd !== 32'h000000A5) begin errs++; $display("FAIL lb_13 got %h want 000000a5", t_rd); end
    access(0, 0, 1, 32'h11, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_rd !== 32'h00000033) begin errs++; $display("FAIL lb_11 got %h want 00000033", t_rd); end
  endtask

  task automatic test_fault();
    access(0, 1, 0, 32'h0, 32'h01020304, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    access(0, 0, 0, 32'h12, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_err !== 1'b1) begin errs++; $display("FAIL mis_err got %b want 1", t_err); end
    vecs++; if (t_rd !== 32'h0) begin errs++; $display("FAIL mis_rdata got %h want 00000000", t_rd); end
    vecs++; if (t_erra !== 1'b0) begin errs++; $display("FAIL mis_pulse got %b want 0", t_erra); end
    access(0, 1, 0, 32'h100, 32'hCAFEF00D, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_err !== 1'b1) begin errs++; $display("FAIL oor_err got %b want 1", t_err); end
    vecs++; if (t_erra !== 1'b0) begin errs++; $display("FAIL oor_pulse got %b want 0", t_erra); end
    access(0, 1, 0, 32'h12, 32'hFFFFFFFF, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_err !== 1'b1) begin errs++; $display("FAIL missw_err got %b want 1", t_err); end
    access(0, 0, 0, 32'h0, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_rd !== 32'h01020304) begin errs++; $display("FAIL oor_mem got %h want 01020304", t_rd); end
    vecs++; if (t_err !== 1'b0) begin errs++; $display("FAIL ok_err got %b want 0", t_err); end
    access(0, 0, 0, 32'h10, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_rd !== 32'hA5223344) begin errs++; $display("FAIL missw_mem got %h want a5223344", t_rd); end
  endtask

  task automatic test_drop();
    access(0, 1, 0, 32'h28, 32'h600DCAFE, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    access(0, 0, 0, 32'h28, 32'h0, 1, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_resp !== 2) begin errs++; $display("FAIL drop_resp got %0d want 2", t_resp); end
    vecs++; if (t_rd !== 32'h600DCAFE) begin errs++; $display("FAIL drop_rdata got %h want 600dcafe", t_rd); end
  endtask

  task automatic test_back_to_back();
    access(1, 1, 0, 32'h20, 32'h0BADF00D, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    access(1, 1, 0, 32'h24, 32'h87654321, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    access(1, 0, 0, 32'h20, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_st !== 1) begin errs++; $display("FAIL b2b1_stall got %0d want 1", t_st); end
    vecs++; if (t_rd !== 32'h0BADF00D) begin errs++; $display("FAIL b2b1_rdata got %h want 0badf00d", t_rd); end
    t_acc2 = t_acc;
    access(1, 0, 0, 32'h24, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_st !== 1) begin errs++; $display("FAIL b2b2_stall got %0d want 1", t_st); end
    vecs++; if (t_acc - t_acc2 !== 2) begin errs++; $display("FAIL b2b_spacing got %0d want 2", t_acc - t_acc2); end
    vecs++; if (t_rd !== 32'h87654321) begin errs++; $display("FAIL b2b2_rdata got %h want 87654321", t_rd); end
  endtask

  task automatic test_reset_mid();
    access(0, 1, 0, 32'h20, 32'h11111111, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    access(0, 0, 0, 32'h20, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    mem_write = 1'b1; byte_m = 1'b0; alu_result = 32'h20; write_data = 32'h00000055; req_a = 1'b1;
    @(posedge clk); #1;
    vecs++; if (stall_a !== 1'b1) begin errs++; $display("FAIL rm_wait got %b want 1", stall_a); end
    reset = 1'b1; #1;
    vecs++; if (stall_a !== 1'b0) begin errs++; $display("FAIL rm_stall got %b want 0", stall_a); end
    vecs++; if (rdata_a !== 32'h0) begin errs++; $display("FAIL rm_rdata got %h want 00000000", rdata_a); end
    @(posedge clk); #1;
    req_a = 1'b0; reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    access(0, 0, 0, 32'h20, 32'h0, 0, t_acc, t_st, t_resp, t_rd, t_err, t_rda, t_erra);
    vecs++; if (t_rd !== 32'h11111111) begin errs++; $display("FAIL rm_mem got %h want 11111111", t_rd); end
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_fault();
    test_drop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
